// File: rtl/out_vid_pkg.sv
// Shared types and field widths for the output-video frame-memory read path.
package out_vid_pkg;

    localparam int unsigned OV_ADRS_W = 19;
    localparam int unsigned OV_DATA_W = 32;
    localparam int unsigned OV_LINE_W = 9;
    localparam int unsigned OV_WORD_W = 9;

    typedef enum logic [2:0] {StIdle, StReq, StGap, StHold, StDone} ov_state_e;

    function automatic logic [OV_ADRS_W-1:0] ov_adrs(input logic bank,
                                                      input logic [OV_LINE_W-1:0] line,
                                                      input logic [OV_WORD_W-1:0] word);
        return {bank, line, word};
    endfunction

endpackage

// File: rtl/out_vid_fifo.sv
// First-word-fall-through read-data FIFO with occupancy count and synchronous flush.
module out_vid_fifo
    import out_vid_pkg::*;
#(
    parameter int unsigned Depth = 16,
    localparam int unsigned PtrW = $clog2(Depth)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush_i,
    input  logic                 wr_en_i,
    input  logic [OV_DATA_W-1:0] wr_data_i,
    input  logic                 rd_en_i,
    output logic [OV_DATA_W-1:0] rd_data_o,
    output logic [PtrW:0]        count_o,
    output logic                 empty_o
);

    logic [OV_DATA_W-1:0] mem_q [Depth];
    logic [PtrW-1:0]      wptr_q, rptr_q;
    logic [PtrW:0]        cnt_q;
    logic                 full, rd_ok, wr_ok;

    assign empty_o = (cnt_q == '0);
    assign full    = (cnt_q == (PtrW+1)'(Depth));
    assign rd_ok   = rd_en_i && !empty_o;
    assign wr_ok   = wr_en_i && (!full || rd_ok);
    assign count_o = cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else if (flush_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (wr_ok) wptr_q <= wptr_q + 1'b1;
            if (rd_ok) rptr_q <= rptr_q + 1'b1;
            cnt_q <= cnt_q + {{PtrW{1'b0}}, wr_ok} - {{PtrW{1'b0}}, rd_ok};
        end
    end

    // Payload storage needs no reset: the head is masked to zero while empty.
    always_ff @(posedge clk) begin
        if (wr_ok && !flush_i) mem_q[wptr_q] <= wr_data_i;
    end

    assign rd_data_o = empty_o ? '0 : mem_q[rptr_q];

endmodule

// File: rtl/out_vid_rd_ctrl.sv
// Output-video frame read initiator: one frame per ovp rise from the bank opposite the writer.
// Optional underrun counter built only when OUT_VID_UNDERRUN_CNT_EN is defined.
module out_vid_rd_ctrl
    import out_vid_pkg::*;
#(
    parameter int unsigned ADRS_W     = 19,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ovp_i,
    input  logic                 frame_alt_i,
    input  logic                 frame_alt_frz_i,
    input  logic [9:0]           h_words_i,
    input  logic [9:0]           v_lines_i,
    input  logic                 fm_cycle_stp_i,
    input  logic [OV_DATA_W-1:0] mem_rd_d_i,
    output logic                 out_vid_rd_cycle_o,
    output logic [ADRS_W-1:0]    out_vid_rd_adrs_o,
    input  logic                 dout_rd_en_i,
    output logic [OV_DATA_W-1:0] dout_o,
    output logic                 dout_valid_o,
    output logic                 frame_busy_o,
    output logic [15:0]          underrun_cnt_o
);

    localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

    ov_state_e              state_q;
    logic                   ovp_q, bank_q, restart_q, rd_cycle_q;
    logic [ADRS_W-1:0]      adrs_q;
    logic [OV_LINE_W-1:0]   line_q;
    logic [OV_WORD_W-1:0]   word_q;
    logic [9:0]             h_q, v_q;

    logic                   ovp_rise, stp_req, restart_now, bank_nxt;
    logic                   last_word, last_line, can_req, size_new_ok, size_now_ok;
    logic                   fifo_wr, fifo_flush, fifo_empty;
    logic [CntW-1:0]        fifo_cnt;

    assign ovp_rise    = ovp_i & ~ovp_q;
    assign stp_req     = fm_cycle_stp_i && (state_q == StReq);
    assign restart_now = restart_q || ovp_rise;
    assign bank_nxt    = frame_alt_frz_i ? bank_q : ~frame_alt_i;
    assign last_word   = ({1'b0, word_q} == h_q - 10'd1);
    assign last_line   = ({1'b0, line_q} == v_q - 10'd1);
    assign can_req     = (fifo_cnt < CntW'(FIFO_DEPTH));
    assign size_new_ok = (h_words_i != '0) && (v_lines_i != '0);
    assign size_now_ok = ovp_rise ? size_new_ok : ((h_q != '0) && (v_q != '0));

    // A word returned after a mid-frame ovp rise belongs to the old frame and is dropped.
    assign fifo_wr    = stp_req && !restart_now;
    assign fifo_flush = (ovp_rise && (state_q != StReq)) || (stp_req && restart_now);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            ovp_q      <= 1'b0;
            bank_q     <= 1'b0;
            restart_q  <= 1'b0;
            rd_cycle_q <= 1'b0;
            adrs_q     <= '0;
            line_q     <= '0;
            word_q     <= '0;
            h_q        <= '0;
            v_q        <= '0;
        end else begin
            ovp_q <= ovp_i;
            if (ovp_rise) begin
                bank_q <= bank_nxt;
                h_q    <= h_words_i;
                v_q    <= v_lines_i;
            end
            case (state_q)
                StReq: begin
                    if (ovp_rise) restart_q <= 1'b1;
                    if (fm_cycle_stp_i) begin
                        rd_cycle_q <= 1'b0;
                        restart_q  <= 1'b0;
                        if (restart_now) begin
                            word_q  <= '0;
                            line_q  <= '0;
                            state_q <= size_now_ok ? StGap : StIdle;
                        end else if (last_word) begin
                            word_q <= '0;
                            if (last_line) begin
                                state_q <= StDone;
                            end else begin
                                line_q  <= line_q + 1'b1;
                                state_q <= StGap;
                            end
                        end else begin
                            word_q  <= word_q + 1'b1;
                            state_q <= StGap;
                        end
                    end
                end
                default: begin
                    if (ovp_rise) begin
                        word_q <= '0;
                        line_q <= '0;
                        if (size_new_ok) begin
                            state_q    <= StReq;
                            rd_cycle_q <= 1'b1;
                            adrs_q     <= ADRS_W'(ov_adrs(bank_nxt, '0, '0));
                        end else begin
                            state_q <= StIdle;
                        end
                    end else if ((state_q == StGap) || (state_q == StHold)) begin
                        if (can_req) begin
                            state_q    <= StReq;
                            rd_cycle_q <= 1'b1;
                            adrs_q     <= ADRS_W'(ov_adrs(bank_q, line_q, word_q));
                        end else begin
                            state_q <= StHold;
                        end
                    end
                end
            endcase
        end
    end

    assign out_vid_rd_cycle_o = rd_cycle_q;
    assign out_vid_rd_adrs_o  = adrs_q;
    assign frame_busy_o       = (state_q == StReq) || (state_q == StGap) || (state_q == StHold);
    assign dout_valid_o       = !fifo_empty;

    out_vid_fifo #(
        .Depth(FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush_i  (fifo_flush),
        .wr_en_i  (fifo_wr),
        .wr_data_i(mem_rd_d_i),
        .rd_en_i  (dout_rd_en_i),
        .rd_data_o(dout_o),
        .count_o  (fifo_cnt),
        .empty_o  (fifo_empty)
    );

`ifdef OUT_VID_UNDERRUN_CNT_EN
    logic [15:0] underrun_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            underrun_q <= '0;
        end else if (ovp_rise) begin
            underrun_q <= '0;
        end else if (dout_rd_en_i && fifo_empty && frame_busy_o && (underrun_q != 16'hFFFF)) begin
            underrun_q <= underrun_q + 16'd1;
        end
    end

    assign underrun_cnt_o = underrun_q;
`else
    assign underrun_cnt_o = '0;
`endif

endmodule

// File: tb/tb_out_vid_rd_ctrl.sv
// Self-checking bench for out_vid_rd_ctrl; underrun expectations follow OUT_VID_UNDERRUN_CNT_EN.
module tb_out_vid_rd_ctrl;

    localparam int unsigned ADRS_W     = 19;
    localparam int unsigned FIFO_DEPTH = 16;
`ifdef OUT_VID_UNDERRUN_CNT_EN
    localparam logic [15:0] UNDERRUN_EXP = 16'd5;
`else
    localparam logic [15:0] UNDERRUN_EXP = 16'd0;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              ovp = 1'b0, frame_alt = 1'b0, frame_alt_frz = 1'b0;
    logic [9:0]        h_words = '0, v_lines = '0;
    logic              fm_cycle_stp = 1'b0;
    logic [31:0]       mem_rd_d = '0;
    logic              out_vid_rd_cycle;
    logic [ADRS_W-1:0] out_vid_rd_adrs;
    logic              dout_rd_en = 1'b0;
    logic [31:0]       dout;
    logic              dout_valid, frame_busy;
    logic [15:0]       underrun_cnt;

    int                n_vec = 0, n_err = 0, req_cnt = 0;
    bit                arb_en = 1'b0, cons_en = 1'b0;
    logic [ADRS_W-1:0] addr_q[$];
    logic [31:0]       data_q[$];

    typedef struct {
        logic [9:0] h;
        logic [9:0] v;
        logic       alt;
        logic       frz;
        logic       exp_bank;
        int         exp_words;
    } frame_vec_t;
    frame_vec_t vecs[8];

    out_vid_rd_ctrl #(
        .ADRS_W    (ADRS_W),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .ovp_i             (ovp),
        .frame_alt_i       (frame_alt),
        .frame_alt_frz_i   (frame_alt_frz),
        .h_words_i         (h_words),
        .v_lines_i         (v_lines),
        .fm_cycle_stp_i    (fm_cycle_stp),
        .mem_rd_d_i        (mem_rd_d),
        .out_vid_rd_cycle_o(out_vid_rd_cycle),
        .out_vid_rd_adrs_o (out_vid_rd_adrs),
        .dout_rd_en_i      (dout_rd_en),
        .dout_o            (dout),
        .dout_valid_o      (dout_valid),
        .frame_busy_o      (frame_busy),
        .underrun_cnt_o    (underrun_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [ADRS_W-1:0] mk(input logic b, input int l, input int w);
        logic [8:0] lv, wv;
        lv = l[8:0];
        wv = w[8:0];
        return {b, lv, wv};
    endfunction

    function automatic logic [31:0] data_of(input logic [ADRS_W-1:0] a);
        return {13'h1A5, a};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic pulse_ovp();
        @(negedge clk);
        ovp = 1'b1;
        repeat (2) @(negedge clk);
        ovp = 1'b0;
    endtask

    task automatic wait_frame_end(input string name);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (addr_q.size() == 0 && data_q.size() == 0 && !dout_valid && !frame_busy &&
                !out_vid_rd_cycle) begin
                done = 1'b1;
                break;
            end
        end
        check({name, "_done"}, {31'd0, done}, 32'd1);
        repeat (10) @(negedge clk);
    endtask

    // Arbiter model: answers each request after three sampled cycles and checks its address.
    initial begin : arbiter
        int cnt;
        logic [ADRS_W-1:0] a;
        cnt = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!arb_en) begin
                cnt = 0;
            end else if (fm_cycle_stp) begin
                fm_cycle_stp = 1'b0;
                cnt = 0;
            end else if (out_vid_rd_cycle) begin
                cnt++;
                if (cnt == 3) begin
                    if (addr_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL rd_adrs_extra: got %0h expected none", out_vid_rd_adrs);
                    end else begin
                        a = addr_q.pop_front();
                        check("rd_adrs", 32'(out_vid_rd_adrs), 32'(a));
                        data_q.push_back(data_of(a));
                    end
                    mem_rd_d     = data_of(out_vid_rd_adrs);
                    fm_cycle_stp = 1'b1;
                    req_cnt++;
                    cnt = 0;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    initial begin : consumer
        forever begin
            @(negedge clk);
            if (cons_en) begin
                if (dout_valid) begin
                    if (data_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL dout_extra: got %0h expected none", dout);
                    end else begin
                        check("dout", dout, data_q.pop_front());
                    end
                    dout_rd_en = 1'b1;
                end else begin
                    dout_rd_en = 1'b0;
                end
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin : main
        bit got;
        vecs[0] = '{10'd4, 10'd2, 1'b0, 1'b0, 1'b1, 8};
        vecs[1] = '{10'd3, 10'd3, 1'b1, 1'b0, 1'b0, 9};
        vecs[2] = '{10'd2, 10'd1, 1'b0, 1'b1, 1'b0, 2};
        vecs[3] = '{10'd1, 10'd1, 1'b0, 1'b0, 1'b1, 1};
        vecs[4] = '{10'd0, 10'd5, 1'b1, 1'b0, 1'b0, 0};
        vecs[5] = '{10'd5, 10'd0, 1'b0, 1'b0, 1'b1, 0};
        vecs[6] = '{10'd5, 10'd1, 1'b1, 1'b1, 1'b1, 5};
        vecs[7] = '{10'd2, 10'd2, 1'b1, 1'b0, 1'b0, 4};

        repeat (3) @(negedge clk);
        check("rst_rd_cycle", {31'd0, out_vid_rd_cycle}, 32'd0);
        check("rst_adrs", 32'(out_vid_rd_adrs), 32'd0);
        check("rst_valid", {31'd0, dout_valid}, 32'd0);
        check("rst_dout", dout, 32'd0);
        check("rst_busy", {31'd0, frame_busy}, 32'd0);
        check("rst_underrun", {16'd0, underrun_cnt}, 32'd0);
        rst_n = 1'b1;
        arb_en = 1'b1;
        cons_en = 1'b1;

        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            h_words = vecs[i].h;
            v_lines = vecs[i].v;
            frame_alt = vecs[i].alt;
            frame_alt_frz = vecs[i].frz;
            for (int l = 0; l < int'(vecs[i].v); l++)
                for (int w = 0; w < int'(vecs[i].h); w++)
                    addr_q.push_back(mk(vecs[i].exp_bank, l, w));
            req_cnt = 0;
            pulse_ovp();
            wait_frame_end($sformatf("frame%0d", i));
            check($sformatf("frame%0d_reqs", i), 32'(req_cnt), 32'(vecs[i].exp_words));
            check($sformatf("frame%0d_busy", i), {31'd0, frame_busy}, 32'd0);
        end

        // FIFO fills with no consumer: exactly FIFO_DEPTH fetches, then one per pop.
        @(negedge clk);
        cons_en = 1'b0;
        dout_rd_en = 1'b0;
        h_words = 10'd32;
        v_lines = 10'd1;
        frame_alt = 1'b1;
        frame_alt_frz = 1'b0;
        for (int w = 0; w < 32; w++) addr_q.push_back(mk(1'b0, 0, w));
        req_cnt = 0;
        pulse_ovp();
        repeat (200) @(negedge clk);
        check("hold_reqs", 32'(req_cnt), 32'(FIFO_DEPTH));
        check("hold_rd_cycle", {31'd0, out_vid_rd_cycle}, 32'd0);
        check("hold_busy", {31'd0, frame_busy}, 32'd1);
        check("hold_valid", {31'd0, dout_valid}, 32'd1);
        check("hold_head", dout, data_q.pop_front());
        dout_rd_en = 1'b1;
        @(negedge clk);
        dout_rd_en = 1'b0;
        repeat (40) @(negedge clk);
        check("resume_reqs", 32'(req_cnt), 32'(FIFO_DEPTH + 1));
        check("resume_rd_cycle", {31'd0, out_vid_rd_cycle}, 32'd0);
        cons_en = 1'b1;
        wait_frame_end("hold");
        check("hold_total", 32'(req_cnt), 32'd32);

        // ovp rise while a request is outstanding, with underrun pops beforehand.
        @(negedge clk);
        arb_en = 1'b0;
        cons_en = 1'b0;
        dout_rd_en = 1'b0;
        h_words = 10'd4;
        v_lines = 10'd2;
        frame_alt = 1'b0;
        req_cnt = 0;
        pulse_ovp();
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (out_vid_rd_cycle) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("rs_req_seen", {31'd0, got}, 32'd1);
        check("rs_first_adrs", 32'(out_vid_rd_adrs), 32'(mk(1'b1, 0, 0)));
        dout_rd_en = 1'b1;
        repeat (5) @(negedge clk);
        dout_rd_en = 1'b0;
        @(negedge clk);
        check("underrun_cnt", {16'd0, underrun_cnt}, {16'd0, UNDERRUN_EXP});
        frame_alt = 1'b1;
        pulse_ovp();
        check("rs_hold_req", {31'd0, out_vid_rd_cycle}, 32'd1);
        check("rs_hold_adrs", 32'(out_vid_rd_adrs), 32'(mk(1'b1, 0, 0)));
        check("underrun_clr", {16'd0, underrun_cnt}, 32'd0);
        @(posedge clk);
        #1;
        fm_cycle_stp = 1'b1;
        mem_rd_d = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        fm_cycle_stp = 1'b0;
        repeat (3) @(negedge clk);
        check("rs_discard", {31'd0, dout_valid}, 32'd0);
        check("rs_new_req", {31'd0, out_vid_rd_cycle}, 32'd1);
        check("rs_new_adrs", 32'(out_vid_rd_adrs), 32'(mk(1'b0, 0, 0)));
        for (int l = 0; l < 2; l++)
            for (int w = 0; w < 4; w++) addr_q.push_back(mk(1'b0, l, w));
        req_cnt = 0;
        cons_en = 1'b1;
        arb_en = 1'b1;
        wait_frame_end("restart");
        check("rs_reqs", 32'(req_cnt), 32'd8);

        // Reset in the middle of an outstanding request.
        @(negedge clk);
        arb_en = 1'b0;
        cons_en = 1'b0;
        dout_rd_en = 1'b0;
        pulse_ovp();
        repeat (2) @(negedge clk);
        check("mr_req", {31'd0, out_vid_rd_cycle}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("mr_rd_cycle", {31'd0, out_vid_rd_cycle}, 32'd0);
        check("mr_adrs", 32'(out_vid_rd_adrs), 32'd0);
        check("mr_busy", {31'd0, frame_busy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
